// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - multi-cycle ALU with valid/ready handshakes, bit-serial shifts and shift-add multiply
//
// Ports:
//   Clock     in   rising-edge system clock
//   Reset     in   asynchronous, active-high reset
//   InValid   in   operand/op bundle valid
//   InReady   out  block can accept a bundle (only in IDLE)
//   A         in   operand A
//   B         in   operand B; B[SHW-1:0] is the shift distance
//   FunSel    in   operation select
//   WF        in   write flags for this operation
//   OutValid  out  ALUOut valid (DONE state)
//   OutReady  in   consumer accepts ALUOut
//   ALUOut    out  registered result
//   FlagsOut  out  registered flags {Z, C, N, O}

module multicycle_alu #(
  parameter int WIDTH  = 32,
  parameter int SHW    = $clog2(WIDTH),
  parameter int MUL_EN = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       FunSel,
  input  logic             WF,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUOut,
  output logic [3:0]       FlagsOut
);

  localparam logic [3:0] OP_PASS_A = 4'b0000;
  localparam logic [3:0] OP_PASS_B = 4'b0001;
  localparam logic [3:0] OP_NOT_A  = 4'b0010;
  localparam logic [3:0] OP_NOT_B  = 4'b0011;
  localparam logic [3:0] OP_ADD    = 4'b0100;
  localparam logic [3:0] OP_ADC    = 4'b0101;
  localparam logic [3:0] OP_SUB    = 4'b0110;
  localparam logic [3:0] OP_AND    = 4'b0111;
  localparam logic [3:0] OP_OR     = 4'b1000;
  localparam logic [3:0] OP_XOR    = 4'b1001;
  localparam logic [3:0] OP_NAND   = 4'b1010;
  localparam logic [3:0] OP_LSL    = 4'b1011;
  localparam logic [3:0] OP_LSR    = 4'b1100;
  localparam logic [3:0] OP_ASR    = 4'b1101;
  localparam logic [3:0] OP_MUL    = 4'b1110;
  localparam logic [3:0] OP_ROR    = 4'b1111;

  // Step counter must hold WIDTH itself for the multiply, hence SHW+1 bits.
  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);
  localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [3:0]       op_r;
  logic             wf_r;
  logic [WIDTH-1:0] mcand;   // multiplicand (A) for the shift-add loop
  logic [WIDTH-1:0] work;    // shift register / low half of the product
  logic [WIDTH-1:0] hi;      // high half of the partial product
  logic [SHW:0]     cnt;

  // ---------------------------------------------------------------
  // Single-cycle path, evaluated directly from the incoming bundle so
  // the accept edge can go straight to DONE.
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] fast_res;
  logic             fast_c;
  logic             fast_o;
  logic             is_shift;
  logic             is_mul;
  logic             fast_path;

  always_comb begin
    add_b   = (FunSel == OP_SUB) ? ~B : B;
    add_cin = (FunSel == OP_SUB) ? 1'b1 :
              (FunSel == OP_ADC) ? FlagsOut[2] : 1'b0;
    sum_ext = {1'b0, A} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    fast_res = A;
    fast_c   = FlagsOut[2];
    fast_o   = FlagsOut[0];

    case (FunSel)
      OP_PASS_A: fast_res = A;
      OP_PASS_B: fast_res = B;
      OP_NOT_A:  fast_res = ~A;
      OP_NOT_B:  fast_res = ~B;
      OP_ADD, OP_ADC: begin
        fast_res = sum_ext[WIDTH-1:0];
        fast_c   = sum_ext[WIDTH];
        fast_o   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        fast_res = sum_ext[WIDTH-1:0];
        fast_c   = sum_ext[WIDTH];
        fast_o   = (A[WIDTH-1] != B[WIDTH-1]) && (sum_ext[WIDTH-1] == B[WIDTH-1]);
      end
      OP_AND:    fast_res = A & B;
      OP_OR:     fast_res = A | B;
      OP_XOR:    fast_res = A ^ B;
      OP_NAND:   fast_res = ~(A & B);
      // Zero-distance shifts and the disabled multiply pass A through.
      default:   fast_res = A;
    endcase

    is_shift  = (FunSel == OP_LSL) || (FunSel == OP_LSR) ||
                (FunSel == OP_ASR) || (FunSel == OP_ROR);
    is_mul    = (MUL_EN != 0) && (FunSel == OP_MUL);
    fast_path = !is_mul && !(is_shift && (B[SHW-1:0] != '0));
  end

  // ---------------------------------------------------------------
  // One iteration of a multi-cycle operation.
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] step_res;
  logic [WIDTH-1:0] step_hi;
  logic             step_c;
  logic [WIDTH:0]   mul_sum;

  always_comb begin
    step_res = work;
    step_hi  = hi;
    step_c   = 1'b0;
    mul_sum  = '0;
    case (op_r)
      OP_LSL: begin
        step_c   = work[WIDTH-1];
        step_res = {work[WIDTH-2:0], 1'b0};
      end
      OP_LSR: begin
        step_c   = work[0];
        step_res = {1'b0, work[WIDTH-1:1]};
      end
      OP_ASR: begin
        step_c   = work[0];
        step_res = {work[WIDTH-1], work[WIDTH-1:1]};
      end
      OP_ROR: begin
        step_c   = work[0];
        step_res = {work[0], work[WIDTH-1:1]};
      end
      default: begin
        // Shift-add: conditionally add the multiplicand into the high
        // half, then shift the whole {carry, hi, lo} pair right by one.
        mul_sum             = {1'b0, hi} + (work[0] ? {1'b0, mcand} : '0);
        {step_hi, step_res} = {mul_sum, work[WIDTH-1:1]};
        step_c              = |step_hi;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Control FSM with registered handshake outputs.
  // ---------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      InReady  <= 1'b1;
      OutValid <= 1'b0;
      ALUOut   <= '0;
      FlagsOut <= '0;
      op_r     <= '0;
      wf_r     <= 1'b0;
      mcand    <= '0;
      work     <= '0;
      hi       <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (InValid) begin
            op_r    <= FunSel;
            wf_r    <= WF;
            mcand   <= A;
            InReady <= 1'b0;
            if (fast_path) begin
              ALUOut   <= fast_res;
              OutValid <= 1'b1;
              state    <= DONE;
              if (WF)
                FlagsOut <= {~|fast_res, fast_c, fast_res[WIDTH-1], fast_o};
            end else begin
              state <= BUSY;
              hi    <= '0;
              if (is_mul) begin
                work <= B;
                cnt  <= CNT_MUL;
              end else begin
                work <= A;
                cnt  <= {1'b0, B[SHW-1:0]};
              end
            end
          end
        end

        BUSY: begin
          work <= step_res;
          hi   <= step_hi;
          cnt  <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            ALUOut   <= step_res;
            OutValid <= 1'b1;
            state    <= DONE;
            if (wf_r)
              FlagsOut <= {~|step_res, step_c, step_res[WIDTH-1], FlagsOut[0]};
          end
        end

        DONE: begin
          // Returning to IDLE raises InReady on the next edge, so a bundle
          // waiting at the input is not taken in the hand-off cycle.
          if (OutReady) begin
            OutValid <= 1'b0;
            InReady  <= 1'b1;
            state    <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          InReady  <= 1'b1;
          OutValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - self-checking bench for multicycle_alu against a behavioural model

module tb_multicycle_alu;

  localparam int W = 32;

  localparam logic [3:0] OP_PASS_A = 4'b0000;
  localparam logic [3:0] OP_PASS_B = 4'b0001;
  localparam logic [3:0] OP_NOT_A  = 4'b0010;
  localparam logic [3:0] OP_NOT_B  = 4'b0011;
  localparam logic [3:0] OP_ADD    = 4'b0100;
  localparam logic [3:0] OP_ADC    = 4'b0101;
  localparam logic [3:0] OP_SUB    = 4'b0110;
  localparam logic [3:0] OP_AND    = 4'b0111;
  localparam logic [3:0] OP_OR     = 4'b1000;
  localparam logic [3:0] OP_XOR    = 4'b1001;
  localparam logic [3:0] OP_NAND   = 4'b1010;
  localparam logic [3:0] OP_LSL    = 4'b1011;
  localparam logic [3:0] OP_LSR    = 4'b1100;
  localparam logic [3:0] OP_ASR    = 4'b1101;
  localparam logic [3:0] OP_MUL    = 4'b1110;
  localparam logic [3:0] OP_ROR    = 4'b1111;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         InValid;
  logic         InReady;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   FunSel;
  logic         WF;
  logic         OutValid;
  logic         OutReady;
  logic [W-1:0] ALUOut;
  logic [3:0]   FlagsOut;

  always #5 Clock = ~Clock;

  multicycle_alu #(.WIDTH(W), .MUL_EN(1)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .A        (A),
    .B        (B),
    .FunSel   (FunSel),
    .WF       (WF),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .ALUOut   (ALUOut),
    .FlagsOut (FlagsOut)
  );

  int nchecks = 0;
  int nerr    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: plain arithmetic on the whole operand.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic wf, input logic [3:0] fl,
                                output logic [31:0] r, output logic [3:0] f, output int lat);
    logic        c, o;
    logic [32:0] s;
    logic [63:0] p;
    int          sh;
    c   = fl[2];
    o   = fl[0];
    sh  = int'(b[4:0]);
    lat = 1;
    r   = a;
    case (op)
      OP_PASS_A: r = a;
      OP_PASS_B: r = b;
      OP_NOT_A:  r = ~a;
      OP_NOT_B:  r = ~b;
      OP_ADD, OP_ADC: begin
        s = {1'b0, a} + {1'b0, b} + ((op == OP_ADC) ? 33'(fl[2]) : 33'd0);
        r = s[31:0];
        c = s[32];
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_SUB: begin
        r = a - b;
        c = (a >= b);
        o = (a[31] != b[31]) && (r[31] == b[31]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_LSL: begin
        r = a << sh;
        if (sh != 0) c = a[32-sh];
        lat = sh + 1;
      end
      OP_LSR: begin
        r = a >> sh;
        if (sh != 0) c = a[sh-1];
        lat = sh + 1;
      end
      OP_ASR: begin
        r = $unsigned($signed(a) >>> sh);
        if (sh != 0) c = a[sh-1];
        lat = sh + 1;
      end
      OP_ROR: begin
        r = (a >> sh) | (a << (32 - sh));
        if (sh != 0) c = a[sh-1];
        lat = sh + 1;
      end
      default: begin
        p   = {32'd0, a} * {32'd0, b};
        r   = p[31:0];
        c   = |p[63:32];
        lat = 33;
      end
    endcase
    f = wf ? {(r == 32'd0), c, r[31], o} : fl;
  endfunction

  // Expectations published by the driver for the compare process.
  logic [31:0] exp_res;
  logic [3:0]  exp_flags;
  int          exp_lat;
  logic        active;
  logic [3:0]  model_flags;
  int          cyc;

  // Compare process: every negedge while an operation is in flight.
  always @(negedge Clock) begin
    if (!active || Reset) begin
      cyc = 0;
    end else begin
      cyc++;
      chk("in_ready_inflight", InReady, 0);
      if (cyc < exp_lat) begin
        chk("out_valid_early", OutValid, 0);
      end else begin
        chk("out_valid", OutValid, 1);
        chk("alu_out", ALUOut, exp_res);
        chk("flags_out", FlagsOut, exp_flags);
      end
    end
  end

  task automatic pin(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] fl, input logic [31:0] er, input logic [3:0] ef, input int el);
    logic [31:0] r;
    logic [3:0]  f;
    int          l;
    model(op, a, b, 1'b1, fl, r, f, l);
    chk({name, "_res"}, r, er);
    chk({name, "_flags"}, f, ef);
    chk({name, "_lat"}, l, el);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic wf, input int hold);
    logic [31:0] r;
    logic [3:0]  f;
    int          l;
    logic        got;
    model(op, a, b, wf, model_flags, r, f, l);
    exp_res   = r;
    exp_flags = f;
    exp_lat   = l;
    chk("in_ready_idle", InReady, 1);
    FunSel  = op;
    A       = a;
    B       = b;
    WF      = wf;
    InValid = 1'b1;
    @(posedge Clock); #1;
    InValid     = 1'b0;
    A           = $urandom;
    B           = $urandom;
    active      = 1'b1;
    model_flags = f;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (OutValid) begin
        got = 1'b1;
        break;
      end
      @(posedge Clock); #1;
    end
    chk("out_valid_timeout", got, 1);
    if (hold > 0) begin
      InValid = 1'b1;
      FunSel  = OP_ADD;
      WF      = 1'b1;
      repeat (hold) begin
        @(posedge Clock); #1;
      end
      InValid = 1'b0;
    end
    OutReady = 1'b1;
    @(posedge Clock); #1;
    OutReady = 1'b0;
    active   = 1'b0;
    chk("in_ready_after", InReady, 1);
    chk("out_valid_after", OutValid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset       = 1'b1;
    InValid     = 1'b0;
    OutReady    = 1'b0;
    WF          = 1'b0;
    FunSel      = '0;
    A           = '0;
    B           = '0;
    active      = 1'b0;
    model_flags = '0;
    exp_res     = '0;
    exp_flags   = '0;
    exp_lat     = 1;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_in_ready", InReady, 1);
    chk("rst_out_valid", OutValid, 0);
    chk("rst_alu_out", ALUOut, 0);
    chk("rst_flags", FlagsOut, 0);
    Reset = 1'b0;
    @(posedge Clock); #1;

    // Hand-computed values that pin the model.
    pin("pin_add_wrap", OP_ADD, 32'hFFFFFFFF, 32'h1, 4'b0000, 32'h0, 4'b1100, 1);
    pin("pin_add_ovf",  OP_ADD, 32'h7FFFFFFF, 32'h1, 4'b0000, 32'h80000000, 4'b0011, 1);
    pin("pin_adc_c0",   OP_ADC, 32'h0, 32'h0, 4'b0011, 32'h0, 4'b1000, 1);
    pin("pin_lsl1",     OP_LSL, 32'h80000001, 32'h1, 4'b1000, 32'h2, 4'b0100, 2);
    pin("pin_asr4",     OP_ASR, 32'h80000000, 32'h4, 4'b0000, 32'hF8000000, 4'b0010, 5);
    pin("pin_lsr0",     OP_LSR, 32'h12345678, 32'h0, 4'b0100, 32'h12345678, 4'b0100, 1);
    pin("pin_mul_big",  OP_MUL, 32'h00010000, 32'h00010000, 4'b0000, 32'h0, 4'b1100, 33);
    pin("pin_mul_3x5",  OP_MUL, 32'h3, 32'h5, 4'b1100, 32'hF, 4'b0000, 33);
    pin("pin_sub_ovf",  OP_SUB, 32'h80000000, 32'h1, 4'b0000, 32'h7FFFFFFF, 4'b0101, 1);
    pin("pin_ror1",     OP_ROR, 32'h1, 32'h1, 4'b0000, 32'h80000000, 4'b0110, 2);

    // Directed vectors against the DUT.
    run_op(OP_ADD,    32'hFFFFFFFF, 32'h00000001, 1'b1, 0);
    run_op(OP_ADD,    32'h7FFFFFFF, 32'h00000001, 1'b1, 0);
    run_op(OP_ADC,    32'h00000000, 32'h00000000, 1'b1, 0);
    run_op(OP_LSL,    32'h80000001, 32'h00000001, 1'b1, 0);
    run_op(OP_ASR,    32'h80000000, 32'h00000004, 1'b1, 0);
    run_op(OP_LSR,    32'h12345678, 32'h00000000, 1'b1, 0);
    run_op(OP_MUL,    32'h00010000, 32'h00010000, 1'b1, 0);
    run_op(OP_MUL,    32'h00000003, 32'h00000005, 1'b1, 0);
    run_op(OP_SUB,    32'h80000000, 32'h00000001, 1'b1, 5);
    run_op(OP_XOR,    32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 5);
    run_op(OP_ROR,    32'h00000001, 32'h00000001, 1'b1, 0);
    run_op(OP_ADC,    32'h00000001, 32'h00000001, 1'b1, 0);
    run_op(OP_SUB,    32'h00000005, 32'h00000007, 1'b1, 0);
    run_op(OP_NAND,   32'hFFFF0000, 32'hFF00FF00, 1'b1, 0);
    run_op(OP_OR,     32'h00000000, 32'h00000000, 1'b1, 2);
    run_op(OP_AND,    32'hDEADBEEF, 32'h0F0F0F0F, 1'b1, 0);
    run_op(OP_PASS_A, 32'hCAFEF00D, 32'h00000000, 1'b1, 0);
    run_op(OP_PASS_B, 32'h00000000, 32'h80000000, 1'b1, 0);
    run_op(OP_NOT_A,  32'hFFFFFFFF, 32'h12345678, 1'b1, 0);
    run_op(OP_NOT_B,  32'h00000000, 32'h0000FFFF, 1'b0, 0);
    run_op(OP_LSR,    32'hA5A5A5A5, 32'hFFFFFF25, 1'b1, 0);
    run_op(OP_LSL,    32'h00000003, 32'h0000001F, 1'b1, 0);
    run_op(OP_ROR,    32'h80000003, 32'h0000001F, 1'b1, 0);
    run_op(OP_ASR,    32'h40000001, 32'h00000002, 1'b1, 0);
    run_op(OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 3);
    run_op(OP_MUL,    32'h12345678, 32'h00000000, 1'b0, 0);

    // Reset in the middle of a multiply: no result, flags cleared at once.
    FunSel  = OP_MUL;
    A       = 32'h00000003;
    B       = 32'h00000005;
    WF      = 1'b1;
    InValid = 1'b1;
    @(posedge Clock); #1;
    InValid = 1'b0;
    repeat (9) @(posedge Clock);
    #1;
    Reset = 1'b1;
    #1;
    chk("midrst_out_valid", OutValid, 0);
    chk("midrst_flags", FlagsOut, 0);
    chk("midrst_in_ready", InReady, 1);
    chk("midrst_alu_out", ALUOut, 0);
    @(posedge Clock); #1;
    Reset       = 1'b0;
    model_flags = '0;
    repeat (40) @(posedge Clock);
    #1;
    chk("midrst_no_result", OutValid, 0);
    chk("midrst_idle", InReady, 1);
    run_op(OP_ADD, 32'h00000002, 32'h00000003, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
